// File: rtl/upsp_frame_ctrl.sv
// Frame sequencer for the bicubic upsampler: admits one source frame per start, tags col/row/eol/eof,
// counts upscaled beats back and pulses done. Define UPSP_WDOG_EN to add a stall watchdog with a sticky cfg_err.
module upsp_frame_ctrl #(
    parameter int SRC_W       = 960,
    parameter int SRC_H       = 540,
    parameter int SCALE       = 4,
    parameter int PIX_W       = 24,
    parameter int OUT_PIX     = 1,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_start,
    output logic                                         cfg_busy,
    output logic                                         cfg_done,
    output logic [15:0]                                  frame_cnt,
`ifdef UPSP_WDOG_EN
    output logic                                         cfg_err,
`endif
    input  logic [PIX_W-1:0]                             ac_upsp_rdata,
    input  logic                                         ac_upsp_rvalid,
    output logic                                         upsp_ac_rready,
    output logic [PIX_W-1:0]                             core_rdata,
    output logic                                         core_rvalid,
    input  logic                                         core_rready,
    output logic [((SRC_W > 1) ? $clog2(SRC_W) : 1)-1:0] core_col,
    output logic [((SRC_H > 1) ? $clog2(SRC_H) : 1)-1:0] core_row,
    output logic                                         core_eol,
    output logic                                         core_eof,
    input  logic [PIX_W*OUT_PIX-1:0]                     core_wdata,
    input  logic                                         core_wvalid,
    output logic                                         core_wready,
    output logic [PIX_W*OUT_PIX-1:0]                     upsp_ac_wdata,
    output logic                                         upsp_ac_wvalid,
    input  logic                                         ac_upsp_wready
);

    localparam int COL_W     = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int ROW_W     = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int IN_BEATS  = SRC_W * SRC_H;
    localparam int OUT_BEATS = IN_BEATS * SCALE * SCALE / OUT_PIX;
    localparam int IN_CW     = $clog2(IN_BEATS) + 1;
    localparam int OUT_CW    = $clog2(OUT_BEATS) + 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SRC_H - 1);
    localparam logic [IN_CW-1:0]  IN_TERM  = IN_CW'(IN_BEATS);
    localparam logic [OUT_CW-1:0] OUT_TERM = OUT_CW'(OUT_BEATS);

    if ((((SRC_W * SRC_H * SCALE * SCALE) % OUT_PIX) != 0) || (WDOG_CYCLES < 1)) begin : g_bad_cfg
        $error("upsp_frame_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IN_CW-1:0]   in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0]  out_cnt_q, out_cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic in_open;
    logic out_open;
    logic in_hs;
    logic out_hs;
    logic start_acc;
    logic wdog_trip;

    assign start_acc = (state_q == S_IDLE) && cfg_start;
    assign in_open   = (state_q == S_FEED) && (in_cnt_q < IN_TERM);
    assign out_open  = ((state_q == S_FEED) || (state_q == S_DRAIN)) && (out_cnt_q < OUT_TERM);

    // Both streams are pure pass-through; the gates only mask valid/ready.
    always_comb begin
        core_rdata     = '0;
        core_rvalid    = 1'b0;
        upsp_ac_rready = 1'b0;
        upsp_ac_wdata  = '0;
        upsp_ac_wvalid = 1'b0;
        core_wready    = 1'b0;
        if (in_open) begin
            core_rdata     = ac_upsp_rdata;
            core_rvalid    = ac_upsp_rvalid;
            upsp_ac_rready = core_rready;
        end
        if (out_open) begin
            upsp_ac_wdata  = core_wdata;
            upsp_ac_wvalid = core_wvalid;
            core_wready    = ac_upsp_wready;
        end
    end

    assign in_hs  = core_rvalid & core_rready;
    assign out_hs = upsp_ac_wvalid & ac_upsp_wready;

    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        if (start_acc) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            col_d     = '0;
            row_d     = '0;
        end else begin
            if (in_hs) begin
                in_cnt_d = in_cnt_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (out_hs) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

`ifdef UPSP_WDOG_EN
    localparam int                 STALL_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_TERM = STALL_W'(WDOG_CYCLES);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    always_comb begin
        stall_d   = '0;
        err_d     = err_q;
        wdog_trip = 1'b0;
        if (start_acc) begin
            err_d = 1'b0;
        end
        if (((state_q == S_FEED) || (state_q == S_DRAIN)) && !in_hs && !out_hs) begin
            stall_d = stall_q + 1'b1;
            if (stall_d == STALL_TERM) begin
                stall_d   = '0;
                err_d     = 1'b1;
                wdog_trip = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign cfg_err = err_q;
`else
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                // A last output beat landing together with the last input goes straight to DONE.
                if ((in_cnt_d == IN_TERM) && (out_cnt_d == OUT_TERM)) begin
                    state_d = S_DONE;
                end else if (in_cnt_d == IN_TERM) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_d == OUT_TERM) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (wdog_trip) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cfg_busy  = (state_q != S_IDLE);
    assign cfg_done  = (state_q == S_DONE);
    assign frame_cnt = frame_cnt_q;
    assign core_col  = col_q;
    assign core_row  = row_q;
    // Sideband is only meaningful while a pixel can be offered to the core.
    assign core_eol  = in_open && (col_q == COL_LAST);
    assign core_eof  = core_eol && (row_q == ROW_LAST);

endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Bench for upsp_frame_ctrl: directed vector table, corner-case sequences and random frames
// compared every cycle against a count-based reference model.
module tb_upsp_frame_ctrl;

    localparam int SRC_W     = 4;
    localparam int SRC_H     = 2;
    localparam int SCALE     = 4;
    localparam int PIX_W     = 24;
    localparam int OUT_PIX   = 1;
    localparam int WDOG      = 16;
    localparam int IN_BEATS  = SRC_W * SRC_H;
    localparam int OUT_BEATS = SRC_W * SRC_H * SCALE * SCALE / OUT_PIX;
    localparam int COL_W     = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int ROW_W     = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int BOUND     = 2000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_start;
    logic                     cfg_busy;
    logic                     cfg_done;
    logic [15:0]              frame_cnt;
`ifdef UPSP_WDOG_EN
    logic                     cfg_err;
`endif
    logic [PIX_W-1:0]         ac_upsp_rdata;
    logic                     ac_upsp_rvalid;
    logic                     upsp_ac_rready;
    logic [PIX_W-1:0]         core_rdata;
    logic                     core_rvalid;
    logic                     core_rready;
    logic [COL_W-1:0]         core_col;
    logic [ROW_W-1:0]         core_row;
    logic                     core_eol;
    logic                     core_eof;
    logic [PIX_W*OUT_PIX-1:0] core_wdata;
    logic                     core_wvalid;
    logic                     core_wready;
    logic [PIX_W*OUT_PIX-1:0] upsp_ac_wdata;
    logic                     upsp_ac_wvalid;
    logic                     ac_upsp_wready;

    always #5 clk = ~clk;

    upsp_frame_ctrl #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .PIX_W(PIX_W),
        .OUT_PIX(OUT_PIX), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .frame_cnt(frame_cnt),
`ifdef UPSP_WDOG_EN
        .cfg_err(cfg_err),
`endif
        .ac_upsp_rdata(ac_upsp_rdata),
        .ac_upsp_rvalid(ac_upsp_rvalid),
        .upsp_ac_rready(upsp_ac_rready),
        .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .core_rready(core_rready),
        .core_col(core_col),
        .core_row(core_row),
        .core_eol(core_eol),
        .core_eof(core_eof),
        .core_wdata(core_wdata),
        .core_wvalid(core_wvalid),
        .core_wready(core_wready),
        .upsp_ac_wdata(upsp_ac_wdata),
        .upsp_ac_wvalid(upsp_ac_wvalid),
        .ac_upsp_wready(ac_upsp_wready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame is just "how many pixels in, how many beats out".
    bit m_active;
    int m_in;
    int m_out;
    int m_frames;
    bit m_err;
    int m_stall;

    function automatic bit m_done_cyc();
        return m_active && (m_in == IN_BEATS) && (m_out == OUT_BEATS);
    endfunction
    function automatic bit m_in_open();
        return m_active && (m_in < IN_BEATS);
    endfunction
    function automatic bit m_out_open();
        return m_active && (m_out < OUT_BEATS);
    endfunction

    task automatic m_reset();
        m_active = 1'b0; m_in = 0; m_out = 0; m_frames = 0; m_err = 1'b0; m_stall = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for cfg_done", name);
    endtask

    task automatic model_check();
        bit io, oo;
        int col, row;
        io  = m_in_open();
        oo  = m_out_open();
        col = m_in % SRC_W;
        row = (m_in / SRC_W) % SRC_H;
        chk("rvalid", 32'(core_rvalid), 32'(io && ac_upsp_rvalid));
        chk("rready", 32'(upsp_ac_rready), 32'(io && core_rready));
        if (io) chk("rdata", 32'(core_rdata), 32'(ac_upsp_rdata));
        chk("wvalid", 32'(upsp_ac_wvalid), 32'(oo && core_wvalid));
        chk("wready", 32'(core_wready), 32'(oo && ac_upsp_wready));
        if (oo) chk("wdata", 32'(upsp_ac_wdata), 32'(core_wdata));
        chk("col", 32'(core_col), 32'(col));
        chk("row", 32'(core_row), 32'(row));
        chk("eol", 32'(core_eol), 32'(io && (col == SRC_W - 1)));
        chk("eof", 32'(core_eof), 32'(io && (col == SRC_W - 1) && (row == SRC_H - 1)));
        chk("busy", 32'(cfg_busy), 32'(m_active));
        chk("done", 32'(cfg_done), 32'(m_done_cyc()));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
`ifdef UPSP_WDOG_EN
        chk("err", 32'(cfg_err), 32'(m_err));
`endif
    endtask

    task automatic model_update();
        bit ih, oh;
        ih = m_in_open() && ac_upsp_rvalid && core_rready;
        oh = m_out_open() && core_wvalid && ac_upsp_wready;
        if (m_active) begin
            if (m_done_cyc()) begin
                m_active = 1'b0;
                m_frames++;
            end else begin
                if (ih) m_in++;
                if (oh) m_out++;
`ifdef UPSP_WDOG_EN
                if (ih || oh) m_stall = 0;
                else begin
                    m_stall++;
                    if (m_stall == WDOG) begin
                        m_active = 1'b0;
                        m_err    = 1'b1;
                        m_stall  = 0;
                    end
                end
`endif
            end
        end else if (cfg_start) begin
            m_active = 1'b1; m_in = 0; m_out = 0; m_err = 1'b0; m_stall = 0;
        end
    endtask

    // Called at posedge+1: drive, then check at posedge+3.
    task automatic drive(input bit st, input bit rv, input bit cr, input bit wv, input bit aw);
        cfg_start      = st;
        ac_upsp_rvalid = rv;
        core_rready    = cr;
        core_wvalid    = wv;
        ac_upsp_wready = aw;
        ac_upsp_rdata  = 24'($urandom);
        core_wdata     = 24'($urandom);
        #2;
        model_check();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 1'b1; ac_upsp_rvalid = 1'b1; core_rready = 1'b1;
        core_wvalid = 1'b1; ac_upsp_wready = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_busy", 32'(cfg_busy), 0);
        chk("rst_done", 32'(cfg_done), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_rready", 32'(upsp_ac_rready), 0);
        chk("rst_rvalid", 32'(core_rvalid), 0);
        chk("rst_wready", 32'(core_wready), 0);
        chk("rst_wvalid", 32'(upsp_ac_wvalid), 0);
        chk("rst_col", 32'(core_col), 0);
        chk("rst_row", 32'(core_row), 0);
        chk("rst_eol", 32'(core_eol), 0);
        chk("rst_eof", 32'(core_eof), 0);
`ifdef UPSP_WDOG_EN
        chk("rst_err", 32'(cfg_err), 0);
`endif
        m_reset();
        rst = 1'b0;
        cfg_start = 1'b0; ac_upsp_rvalid = 1'b0; core_rready = 1'b0;
        core_wvalid = 1'b0; ac_upsp_wready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // mode 0: all valid/ready; 1: wready toggles; 2: random. ign pulses start in FEED and in DONE.
    task automatic run_frame(input int mode, input bit ign, output int ihs, output int ohs, output int dn);
        int cyc, tail;
        bit st, rv, cr, wv, aw;
        cyc = 0; tail = 0; ihs = 0; ohs = 0; dn = 0;
        while (tail < 3) begin
            st = (cyc == 0) || (ign && ((cyc == 3) || m_done_cyc()));
            rv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            cr = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            aw = (mode == 1) ? ((cyc % 2) != 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive(st, rv, cr, wv, aw);
            if (upsp_ac_rready && ac_upsp_rvalid) ihs++;
            if (upsp_ac_wvalid && ac_upsp_wready) ohs++;
            if (cfg_done) dn++;
            if (dn > 0) tail++;
            finish_cycle();
            cyc++;
            if (cyc > BOUND) begin
                timeout_fail("run_frame");
                tail = 3;
            end
        end
    endtask

    typedef struct {
        bit st;
        bit rv;
        bit e_rdy;
        bit e_eol;
        bit e_eof;
        int e_col;
        int e_row;
    } vec_t;

    vec_t tbl [0:9];

    initial begin
        int ihs, ohs, dn, cyc;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};

        rst = 1'b1;
        cfg_start = 1'b0; ac_upsp_rvalid = 1'b0; core_rready = 1'b0;
        core_wvalid = 1'b0; ac_upsp_wready = 1'b0;
        ac_upsp_rdata = '0; core_wdata = '0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Full frame with free-flowing streams.
        run_frame(0, 1'b0, ihs, ohs, dn);
        chk("f1_in_hs", 32'(ihs), 32'(IN_BEATS));
        chk("f1_out_hs", 32'(ohs), 32'(OUT_BEATS));
        chk("f1_done_pulses", 32'(dn), 1);
        chk("f1_frame_cnt", 32'(frame_cnt), 1);
        chk("f1_idle", 32'(cfg_busy), 0);

        // Sideband table; core holds its output stream off during the input phase.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].st, tbl[i].rv, 1'b1, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_rready", i), 32'(upsp_ac_rready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_eol", i), 32'(core_eol), 32'(tbl[i].e_eol));
            chk($sformatf("tbl%0d_eof", i), 32'(core_eof), 32'(tbl[i].e_eof));
            chk($sformatf("tbl%0d_col", i), 32'(core_col), 32'(tbl[i].e_col));
            chk($sformatf("tbl%0d_row", i), 32'(core_row), 32'(tbl[i].e_row));
            finish_cycle();
        end
        ohs = 0; dn = 0; cyc = 0;
        while ((dn == 0) && (cyc < BOUND)) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (upsp_ac_wvalid && ac_upsp_wready) ohs++;
            if (cfg_done) dn++;
            finish_cycle();
            cyc++;
        end
        if (dn == 0) timeout_fail("tbl_drain");
        chk("tbl_out_hs", 32'(ohs), 32'(OUT_BEATS));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("tbl_frame_cnt", 32'(frame_cnt), 2);
        chk("tbl_idle", 32'(cfg_busy), 0);
        finish_cycle();

        // Access controller ready toggling every cycle.
        run_frame(1, 1'b0, ihs, ohs, dn);
        chk("tog_out_hs", 32'(ohs), 32'(OUT_BEATS));
        chk("tog_done_pulses", 32'(dn), 1);
        chk("tog_frame_cnt", 32'(frame_cnt), 3);

        // Reset after five accepted pixels aborts the frame.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        finish_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            finish_cycle();
        end
        chk("mid_col_before_rst", 32'(core_col), 1);
        do_reset();
        run_frame(0, 1'b0, ihs, ohs, dn);
        chk("rst_frame_in_hs", 32'(ihs), 32'(IN_BEATS));
        chk("rst_frame_cnt", 32'(frame_cnt), 1);

        // Start pulses during FEED and DONE are ignored; then a back-to-back frame.
        do_reset();
        run_frame(0, 1'b1, ihs, ohs, dn);
        chk("ign_in_hs", 32'(ihs), 32'(IN_BEATS));
        chk("ign_done_pulses", 32'(dn), 1);
        chk("ign_idle", 32'(cfg_busy), 0);
        run_frame(0, 1'b0, ihs, ohs, dn);
        chk("b2b_frame_cnt", 32'(frame_cnt), 2);

        // Random handshakes on both streams.
        for (int f = 0; f < 4; f++) begin
            run_frame(2, 1'b0, ihs, ohs, dn);
            chk($sformatf("rnd%0d_in_hs", f), 32'(ihs), 32'(IN_BEATS));
            chk($sformatf("rnd%0d_out_hs", f), 32'(ohs), 32'(OUT_BEATS));
            chk($sformatf("rnd%0d_done", f), 32'(dn), 1);
        end
        chk("rnd_frame_cnt", 32'(frame_cnt), 6);

`ifdef UPSP_WDOG_EN
        // Core never returns a beat: watchdog aborts the frame.
        do_reset();
        dn = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        finish_cycle();
        for (int i = 0; i < IN_BEATS; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            finish_cycle();
        end
        for (int i = 0; i < WDOG + 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (cfg_done) dn++;
            finish_cycle();
        end
        chk("wdog_err", 32'(cfg_err), 1);
        chk("wdog_idle", 32'(cfg_busy), 0);
        chk("wdog_no_done", 32'(dn), 0);
        chk("wdog_frame_cnt", 32'(frame_cnt), 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        finish_cycle();
        chk("wdog_err_cleared", 32'(cfg_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/upsp_frame_ctrl.md
Name: upsp_frame_ctrl

Overview:
- Frame-level sequencer between the access controller and the bicubic upsampling core.
- Admits exactly one source frame of pixels into the core per start command and tags each pixel with column, row, end-of-line and end-of-frame sideband.
- Counts upscaled output beats back to the access controller and signals frame completion.
- Gates both streams so that no beat crosses a frame boundary.

Parameters:
SRC_W, 960, source frame width in pixels
SRC_H, 540, source frame height in lines
SCALE, 4, upscale factor per axis
PIX_W, 24, bits per pixel (RGB888)
OUT_PIX, 1, pixels per output beat; SCALE*SCALE*SRC_W*SRC_H must be divisible by OUT_PIX
WDOG_CYCLES, 4096, stall limit used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  single-cycle frame start request
cfg_busy  out  1  frame in progress
cfg_done  out  1  one-cycle pulse at frame completion
frame_cnt  out  16  completed-frame count, wraps at 65535
ac_upsp_rdata  in  PIX_W  source pixel from access controller
ac_upsp_rvalid  in  1  source pixel valid
upsp_ac_rready  out  1  source pixel accepted
core_rdata  out  PIX_W  pixel to core
core_rvalid  out  1  pixel to core valid
core_rready  in  1  core ready
core_col  out  clog2(SRC_W)  column of current core pixel
core_row  out  clog2(SRC_H)  row of current core pixel
core_eol  out  1  current pixel is last of line
core_eof  out  1  current pixel is last of frame
core_wdata  in  PIX_W*OUT_PIX  upscaled beat from core
core_wvalid  in  1  core beat valid
core_wready  out  1  core beat accepted
upsp_ac_wdata  out  PIX_W*OUT_PIX  upscaled beat to access controller
upsp_ac_wvalid  out  1  beat valid
ac_upsp_wready  in  1  access controller ready

Behaviour:
- Reset:
  - State IDLE.
  - cfg_busy=0, cfg_done=0, frame_cnt=0.
  - upsp_ac_rready=0, core_rvalid=0, core_wready=0, upsp_ac_wvalid=0.
  - core_col, core_row, core_eol and core_eof all 0.
  - Reset mid-frame aborts the frame immediately: counters cleared, no done pulse.
- Constants: IN_BEATS = SRC_W*SRC_H; OUT_BEATS = SRC_W*SRC_H*SCALE*SCALE/OUT_PIX.
- States:
  - IDLE: cfg_start -> FEED; clears in_cnt, out_cnt, col and row.
  - FEED: input gate open while in_cnt < IN_BEATS. Last input handshake -> DRAIN. If the last output beat coincides, DONE takes priority.
  - DRAIN: input gate closed; output counting continues. out_cnt reaching OUT_BEATS -> DONE.
  - DONE: one cycle; cfg_done=1 and frame_cnt increments. Next state IDLE.
- cfg_busy=1 in FEED, DRAIN and DONE. cfg_start is ignored unless in IDLE.
- Input path (combinational pass-through, zero latency):
  - When the gate is open: core_rdata=ac_upsp_rdata, core_rvalid=ac_upsp_rvalid, upsp_ac_rready=core_rready.
  - Otherwise core_rvalid=0 and upsp_ac_rready=0.
  - Handshake = core_rvalid & core_rready.
- Position counters:
  - On each input handshake, col increments. At SRC_W-1, col wraps to 0 and row increments.
  - core_eol = (col==SRC_W-1); core_eof = core_eol & (row==SRC_H-1).
  - Both are combinational from the registered col/row and are valid alongside core_rvalid.
- Output path (combinational pass-through):
  - In FEED or DRAIN with out_cnt < OUT_BEATS: upsp_ac_wdata=core_wdata, upsp_ac_wvalid=core_wvalid, core_wready=ac_upsp_wready.
  - Otherwise core_wvalid is held off: core_wready=0, upsp_ac_wvalid=0.
  - A beat offered by the core in IDLE stays pending and is never dropped.
- Counter widths are clog2 of the terminal value plus 1; no counter exceeds its terminal value.
- Simultaneous input and output handshakes in the same cycle are both counted.
- cfg_start arriving in DONE is ignored. It must be reissued in IDLE.

Optional Feature:
- UPSP_WDOG_EN defined:
  - Adds output port cfg_err (1 bit, reset 0).
  - A stall counter clears on any input or output handshake and increments every FEED/DRAIN cycle without one.
  - When it reaches WDOG_CYCLES: go to IDLE, set cfg_err=1 (sticky until next cfg_start), no cfg_done, frame_cnt unchanged.
- UPSP_WDOG_EN undefined: no cfg_err port and no stall counter. The controller waits indefinitely.

Test Plan:
- SRC_W=4, SRC_H=2, SCALE=4, OUT_PIX=1; pulse cfg_start, always-valid/ready streams, core returns 128 beats -> 8 input handshakes, 128 output handshakes, cfg_done pulses once, frame_cnt=1, state back to IDLE.
- Same config; core_eol high on input pixels 3 and 7; core_eof high only on pixel 7; core_row=1 on pixels 4..7; a 9th ac_upsp_rvalid is not accepted (upsp_ac_rready=0).
- ac_upsp_wready toggled 1/0 every cycle -> core_wready mirrors it, no beat lost or duplicated, cfg_done arrives after 128th handshake.
- Assert rst after 5 input handshakes -> all outputs at reset values next cycle; new cfg_start restarts at col=0, row=0; full frame completes with frame_cnt=1.
- cfg_start pulsed during FEED and during DONE -> ignored, in_cnt unaffected; back-to-back frames yield frame_cnt=2.
- With UPSP_WDOG_EN, WDOG_CYCLES=16: hold core_wvalid=0 after input completes -> cfg_err=1 after 16 stall cycles, state IDLE, no cfg_done, frame_cnt=0.
